// File: rtl/sand_physics_engine.sv
`default_nettype none
// ============================================================================
// Module   : sand_physics_engine
// Brief    : In-place falling-sand gravity pass over a 1-bpp frame RAM.
// Revision : 1.0 - initial release
// ============================================================================
module sand_physics_engine #(
    parameter int ACTIVE_COLUMNS = 640,
    parameter int ACTIVE_ROWS    = 480,
    parameter int ADDR_WIDTH     = 19
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic                  start_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [ADDR_WIDTH-1:0] moved_count_o,
    output logic [ADDR_WIDTH-1:0] ram_read_address_o,
    input  logic                  ram_read_data_i,
    output logic                  ram_write_en_o,
    output logic [ADDR_WIDTH-1:0] ram_write_address_o,
    output logic                  ram_write_data_o
);
    localparam int XW = (ACTIVE_COLUMNS > 1) ? $clog2(ACTIVE_COLUMNS) : 1;
    localparam int YW = (ACTIVE_ROWS > 1) ? $clog2(ACTIVE_ROWS) : 1;

    localparam logic [ADDR_WIDTH-1:0] c_cols     = ADDR_WIDTH'(ACTIVE_COLUMNS);
    localparam logic [ADDR_WIDTH-1:0] c_one      = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH-1:0] c_start    = ADDR_WIDTH'((ACTIVE_ROWS - 2) * ACTIVE_COLUMNS);
    localparam logic [ADDR_WIDTH-1:0] c_row_back = ADDR_WIDTH'(2 * ACTIVE_COLUMNS - 1);
    localparam logic [XW-1:0]         c_x_last   = XW'(ACTIVE_COLUMNS - 1);
    localparam logic [XW-1:0]         c_x_one    = XW'(1);
    localparam logic [YW-1:0]         c_y_start  = YW'(ACTIVE_ROWS - 2);
    localparam logic [YW-1:0]         c_y_one    = YW'(1);

    localparam logic [3:0] S_IDLE      = 4'd0;
    localparam logic [3:0] S_READ_C    = 4'd1;
    localparam logic [3:0] S_CHECK_C   = 4'd2;
    localparam logic [3:0] S_CHECK_B   = 4'd3;
    localparam logic [3:0] S_CHECK_D1  = 4'd4;
    localparam logic [3:0] S_CHECK_D2  = 4'd5;
    localparam logic [3:0] S_WRITE_DST = 4'd6;
    localparam logic [3:0] S_WRITE_SRC = 4'd7;
    localparam logic [3:0] S_FINISH    = 4'd8;

    logic [3:0]            r_state;
    logic [XW-1:0]         r_x;
    logic [YW-1:0]         r_y;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [ADDR_WIDTH-1:0] r_cnt;
    logic [ADDR_WIDTH-1:0] r_moved;
    logic                  r_prefer_left;
    logic                  r_d1_left;
    logic                  r_busy;
    logic                  r_done;
    logic                  r_wr_en;
    logic [ADDR_WIDTH-1:0] r_wr_addr;
    logic                  r_wr_data;

    logic [ADDR_WIDTH-1:0] w_below, w_bl, w_br;
    logic [ADDR_WIDTH-1:0] w_first_addr, w_d1_addr, w_second_addr;
    logic [ADDR_WIDTH-1:0] w_cnt_next, w_rd_addr;
    logic                  w_bl_ok, w_br_ok, w_first_ok, w_first_left, w_second_ok;
    logic                  w_last, w_adv;

    always_comb begin
        w_below       = r_addr + c_cols;
        w_bl          = w_below - c_one;
        w_br          = w_below + c_one;
        w_bl_ok       = (r_x != '0);
        w_br_ok       = (r_x != c_x_last);
        w_first_ok    = w_bl_ok | w_br_ok;
        // Falls back to the other side when the preferred diagonal is off-grid.
        w_first_left  = r_prefer_left ? w_bl_ok : ~w_br_ok;
        w_first_addr  = w_first_left ? w_bl : w_br;
        w_d1_addr     = r_d1_left ? w_bl : w_br;
        w_second_addr = r_d1_left ? w_br : w_bl;
        w_second_ok   = r_d1_left ? w_br_ok : w_bl_ok;
        w_last        = (r_x == c_x_last) && (r_y == '0);
        w_cnt_next    = r_cnt;
        if (r_state == S_WRITE_SRC && r_cnt != '1) begin
            w_cnt_next = r_cnt + c_one;
        end

        w_rd_addr = r_addr;
        w_adv     = 1'b0;
        case (r_state)
            S_CHECK_C: begin
                if (ram_read_data_i) w_rd_addr = w_below;
                else                 w_adv     = 1'b1;
            end
            S_CHECK_B: begin
                if (ram_read_data_i) begin
                    if (w_first_ok) w_rd_addr = w_first_addr;
                    else            w_adv     = 1'b1;
                end
            end
            S_CHECK_D1: begin
                if (ram_read_data_i) begin
                    if (w_second_ok) w_rd_addr = w_second_addr;
                    else             w_adv     = 1'b1;
                end
            end
            S_CHECK_D2:  w_adv = ram_read_data_i;
            S_WRITE_SRC: w_adv = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_state       <= S_IDLE;
            r_x           <= '0;
            r_y           <= '0;
            r_addr        <= '0;
            r_cnt         <= '0;
            r_moved       <= '0;
            r_prefer_left <= 1'b1;
            r_d1_left     <= 1'b0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_wr_en       <= 1'b0;
            r_wr_addr     <= '0;
            r_wr_data     <= 1'b0;
        end else begin
            r_wr_en   <= 1'b0;
            r_wr_data <= 1'b0;
            r_done    <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start_i) begin
                        r_cnt   <= '0;
                        r_x     <= '0;
                        r_y     <= c_y_start;
                        r_addr  <= c_start;
                        r_busy  <= 1'b1;
                        r_state <= S_READ_C;
                    end
                end
                S_READ_C:  r_state <= S_CHECK_C;
                S_CHECK_C: if (ram_read_data_i) r_state <= S_CHECK_B;
                S_CHECK_B: begin
                    if (!ram_read_data_i) begin
                        r_wr_en   <= 1'b1;
                        r_wr_addr <= w_below;
                        r_wr_data <= 1'b1;
                        r_state   <= S_WRITE_DST;
                    end else if (w_first_ok) begin
                        r_d1_left <= w_first_left;
                        r_state   <= S_CHECK_D1;
                    end
                end
                S_CHECK_D1: begin
                    if (!ram_read_data_i) begin
                        r_wr_en   <= 1'b1;
                        r_wr_addr <= w_d1_addr;
                        r_wr_data <= 1'b1;
                        r_state   <= S_WRITE_DST;
                    end else if (w_second_ok) begin
                        r_state   <= S_CHECK_D2;
                    end
                end
                S_CHECK_D2: begin
                    if (!ram_read_data_i) begin
                        r_wr_en   <= 1'b1;
                        r_wr_addr <= w_second_addr;
                        r_wr_data <= 1'b1;
                        r_state   <= S_WRITE_DST;
                    end
                end
                S_WRITE_DST: begin
                    r_wr_en   <= 1'b1;
                    r_wr_addr <= r_addr;
                    r_state   <= S_WRITE_SRC;
                end
                S_WRITE_SRC: ;
                S_FINISH: begin
                    r_prefer_left <= ~r_prefer_left;
                    r_state       <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase

            // Step to the next source cell; the row wrap moves up one row.
            if (w_adv) begin
                r_cnt <= w_cnt_next;
                if (w_last) begin
                    r_moved <= w_cnt_next;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b1;
                    r_state <= S_FINISH;
                end else begin
                    if (r_x == c_x_last) begin
                        r_x    <= '0;
                        r_y    <= r_y - c_y_one;
                        r_addr <= r_addr - c_row_back;
                    end else begin
                        r_x    <= r_x + c_x_one;
                        r_addr <= r_addr + c_one;
                    end
                    r_state <= S_READ_C;
                end
            end
        end
    end

    assign busy_o              = r_busy;
    assign done_o              = r_done;
    assign moved_count_o       = r_moved;
    assign ram_read_address_o  = w_rd_addr;
    assign ram_write_en_o      = r_wr_en;
    assign ram_write_address_o = r_wr_addr;
    assign ram_write_data_o    = r_wr_data;
endmodule
`default_nettype wire

// File: tb/tb_sand_physics_engine.sv
`default_nettype none
// ============================================================================
// Module   : tb_sand_physics_engine
// Brief    : Self-checking bench for sand_physics_engine on a 4x4 grid.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sand_physics_engine;
    localparam int C = 4;
    localparam int R = 4;
    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          reset_i = 1'b1;
    logic          start_i = 1'b0;
    logic          busy_o, done_o, ram_write_en_o, ram_write_data_o;
    logic [AW-1:0] moved_count_o, ram_read_address_o, ram_write_address_o;
    logic          rd_q = 1'b0;
    logic [15:0]   mem = '0;
    logic [15:0]   load_vec = '0;
    logic          load_en = 1'b0;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    bit pl = 1'b1;
    bit [15:0] ref_g;
    int exp_a[$], exp_d[$], log_a[$], log_d[$];

    sand_physics_engine #(.ACTIVE_COLUMNS(C), .ACTIVE_ROWS(R), .ADDR_WIDTH(AW)) dut (
        .clk_i(clk), .reset_i(reset_i), .start_i(start_i), .busy_o(busy_o), .done_o(done_o),
        .moved_count_o(moved_count_o), .ram_read_address_o(ram_read_address_o),
        .ram_read_data_i(rd_q), .ram_write_en_o(ram_write_en_o),
        .ram_write_address_o(ram_write_address_o), .ram_write_data_o(ram_write_data_o)
    );

    always #5 clk = ~clk;

    // Frame RAM: one-cycle synchronous read, plus a bench-side bulk load.
    always @(posedge clk) begin
        cyc  <= cyc + 1;
        rd_q <= mem[ram_read_address_o];
        if (load_en) mem <= load_vec;
        else if (ram_write_en_o) mem[ram_write_address_o] <= ram_write_data_o;
        if (ram_write_en_o) begin
            log_a.push_back(int'(ram_write_address_o));
            log_d.push_back(int'(ram_write_data_o));
        end
    end

    task automatic check(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Reference pass: grains visited bottom-up, each tries below, then the two diagonals.
    task automatic model_pass(output int cycles, output int moves);
        int a, b, dst;
        int cand[$];
        cycles = 1;
        moves = 0;
        exp_a = {};
        exp_d = {};
        for (int y = R - 2; y >= 0; y--) begin
            for (int x = 0; x < C; x++) begin
                a = y * C + x;
                if (!ref_g[a]) begin
                    cycles += 2;
                    continue;
                end
                b = a + C;
                dst = -1;
                cycles += 3;
                if (!ref_g[b]) dst = b;
                else begin
                    cand = {};
                    if (pl) begin
                        if (x > 0) cand.push_back(b - 1);
                        if (x < C - 1) cand.push_back(b + 1);
                    end else begin
                        if (x < C - 1) cand.push_back(b + 1);
                        if (x > 0) cand.push_back(b - 1);
                    end
                    foreach (cand[i]) begin
                        cycles += 1;
                        if (!ref_g[cand[i]]) begin
                            dst = cand[i];
                            break;
                        end
                    end
                end
                if (dst >= 0) begin
                    ref_g[dst] = 1'b1;
                    ref_g[a] = 1'b0;
                    cycles += 2;
                    moves++;
                    exp_a.push_back(dst); exp_d.push_back(1);
                    exp_a.push_back(a);   exp_d.push_back(0);
                end
            end
        end
    endtask

    task automatic load(input logic [15:0] g);
        load_vec = g;
        load_en = 1'b1;
        @(negedge clk);
        load_en = 1'b0;
        ref_g = g;
    endtask

    task automatic do_reset();
        reset_i = 1'b1;
        repeat (2) @(negedge clk);
        reset_i = 1'b0;
        pl = 1'b1;
    endtask

    task automatic run_pass(input string tag);
        int exp_cyc, exp_mv, s, base, nw;
        bit seen;
        model_pass(exp_cyc, exp_mv);
        base = log_a.size();
        start_i = 1'b1;
        s = cyc;
        @(negedge clk);
        start_i = 1'b0;
        check({tag, "_busy"}, int'(busy_o), 1);
        seen = 1'b0;
        for (int k = 0; k < 400; k++) begin
            if (done_o) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check({tag, "_done_seen"}, int'(seen), 1);
        check({tag, "_latency"}, cyc - s, exp_cyc);
        check({tag, "_moved"}, int'(moved_count_o), exp_mv);
        check({tag, "_busy_at_done"}, int'(busy_o), 0);
        nw = log_a.size() - base;
        check({tag, "_nwrites"}, nw, exp_a.size());
        for (int i = 0; i < exp_a.size() && i < nw; i++) begin
            check({tag, "_wr_addr"}, log_a[base + i], exp_a[i]);
            check({tag, "_wr_data"}, log_d[base + i], exp_d[i]);
        end
        @(negedge clk);
        check({tag, "_done_pulse"}, int'(done_o), 0);
        check({tag, "_grid"}, int'(mem), int'(ref_g));
        pl = ~pl;
    endtask

    initial begin
        int s, gap;
        bit seen;
        do_reset();
        check("rst_busy", int'(busy_o), 0);
        check("rst_done", int'(done_o), 0);
        check("rst_moved", int'(moved_count_o), 0);
        check("rst_we", int'(ram_write_en_o), 0);
        check("rst_wa", int'(ram_write_address_o), 0);
        check("rst_wd", int'(ram_write_data_o), 0);
        check("rst_ra", int'(ram_read_address_o), 0);

        load(16'h0000);
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        check("first_read_addr", int'(ram_read_address_o), 8);
        repeat (30) @(negedge clk);
        load(16'h0000);
        pl = ~pl;
        run_pass("empty");

        load(16'h0002);
        for (int p = 0; p < 4; p++) run_pass("single");
        check("single_final", int'(mem), 16'h2000);

        do_reset();
        load(16'h2200);
        run_pass("stack_left");
        check("stack_left_grid", int'(mem), 16'h3000);

        do_reset();
        load(16'h0000);
        run_pass("toggle");
        load(16'h3200);
        run_pass("stack_right");
        check("stack_right_grid", int'(mem), 16'h7000);

        load(16'hF900);
        run_pass("edges_a");
        run_pass("edges_b");
        check("edges_grid", int'(mem), 16'hF900);

        // Held start: exactly one extra pass begins from the IDLE cycle after FINISH.
        load(16'h0000);
        start_i = 1'b1;
        s = cyc;
        seen = 1'b0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (done_o) begin
                seen = 1'b1;
                break;
            end
        end
        check("held_first_done", int'(seen), 1);
        check("held_first_latency", cyc - s, 25);
        s = cyc;
        @(negedge clk);
        check("held_idle_busy", int'(busy_o), 0);
        @(negedge clk);
        check("held_restart_busy", int'(busy_o), 1);
        start_i = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (done_o) begin
                seen = 1'b1;
                break;
            end
        end
        gap = cyc - s;
        check("held_second_done", int'(seen), 1);
        check("held_gap", gap, 26);
        repeat (5) @(negedge clk);
        check("held_no_third", int'(busy_o), 0);

        for (int r = 0; r < 5; r++) begin
            load(16'($urandom));
            for (int p = 0; p < 3; p++) run_pass("random");
        end

        // Reset landing on the WRITE_DST cycle leaves the destination written only.
        do_reset();
        load(16'h0200);
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 100; k++) begin
            if (ram_write_en_o && ram_write_data_o) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check("mid_dst_seen", int'(seen), 1);
        check("mid_dst_addr", int'(ram_write_address_o), 13);
        reset_i = 1'b1;
        @(negedge clk);
        check("mid_rst_we", int'(ram_write_en_o), 0);
        check("mid_rst_busy", int'(busy_o), 0);
        reset_i = 1'b0;
        pl = 1'b1;
        @(negedge clk);
        check("mid_rst_grid", int'(mem), 16'h2200);
        ref_g = 16'h2200;
        run_pass("post_reset_pref");
        check("post_reset_grid", int'(mem), 16'h3000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/sand_physics_engine.md
# sand_physics_engine

Per-pass falling-sand update engine that sits directly upstream of the 1-bit-per-pixel frame RAM. The engine is the RAM's only writer: it reads the grid through the RAM's synchronous read port and drives the write port. On each `start_i` pulse it performs one in-place gravity pass. In that pass every sand grain falls at most one row, moving straight down or diagonally. The display path keeps reading the same RAM for scan-out.

## Interface
- `ACTIVE_COLUMNS`, default 640: grid width in cells.
- `ACTIVE_ROWS`, default 480: grid height in cells.
- `ADDR_WIDTH`, default 19: cell address width; must satisfy 2^ADDR_WIDTH ≥ ACTIVE_COLUMNS*ACTIVE_ROWS.
- `clk_i`, input, 1: the single clock.
- `reset_i`, input, 1: synchronous, active-high reset.
- `start_i`, input, 1: pass request; sampled only in IDLE.
- `busy_o`, output, 1: high while a pass is in progress.
- `done_o`, output, 1: one-cycle pulse when a pass completes.
- `moved_count_o`, output, ADDR_WIDTH: number of grains moved in the last completed pass.
- `ram_read_address_o`, output, ADDR_WIDTH: read address; data returns 1 cycle later.
- `ram_read_data_i`, input, 1: cell value (1 = sand, 0 = empty).
- `ram_write_en_o`, output, 1: write strobe.
- `ram_write_address_o`, output, ADDR_WIDTH: write address.
- `ram_write_data_o`, output, 1: write data.

## Operation
**Addressing and scan order**
- Cell address = y*ACTIVE_COLUMNS + x (row-major).
- The engine tracks x, y and the address incrementally; no multiplier.
- Neighbour addresses:
  - below = addr + ACTIVE_COLUMNS
  - below-left (BL) = below − 1
  - below-right (BR) = below + 1
- Scan: y runs from ACTIVE_ROWS−2 down to 0. Within each row, x runs from 0 to ACTIVE_COLUMNS−1.
- The bottom row is never a source cell.
- Bottom-up scan ensures each grain moves at most once per pass.

**Diagonal preference**
- `prefer_left` register: reset value 1; toggles when each pass's `done_o` fires.
- First diagonal tried = BL if `prefer_left` is 1, else BR. Second diagonal = the other one.
- Edge rule: BL is unavailable at x=0; BR is unavailable at x=ACTIVE_COLUMNS−1. An unavailable candidate is skipped with no read issued and no cycle spent.

**States**
- IDLE: waits for `start_i`.
  - On `start_i`: clear the move counter, set x=0 and y=ACTIVE_ROWS−2, go to READ_C.
- READ_C: drive the current cell address on the read port; go to CHECK_C.
- CHECK_C:
  - Data 0: advance the cell; go to READ_C, or to FINISH after the last cell.
  - Data 1: issue the below read; go to CHECK_B.
- CHECK_B:
  - Data 0: dst = below; go to WRITE_DST.
  - Otherwise: issue the first available diagonal read, go to CHECK_D1. If no diagonal is available, advance the cell.
- CHECK_D1:
  - Data 0: dst = that diagonal; go to WRITE_DST.
  - Otherwise: issue the other diagonal if available and go to CHECK_D2; else advance the cell.
- CHECK_D2:
  - Data 0: dst = that diagonal; go to WRITE_DST.
  - Otherwise: advance the cell.
- WRITE_DST: write 1 to dst; go to WRITE_SRC.
- WRITE_SRC: write 0 to the current cell; increment the move counter; advance the cell.
- FINISH: latch `moved_count_o`, pulse `done_o`, toggle `prefer_left`, go to IDLE.

**Other rules**
- `ram_write_en_o` is high only in WRITE_DST and WRITE_SRC.
- `start_i` outside IDLE is ignored.
- The move counter saturates at 2^ADDR_WIDTH−1 (unreachable at default sizes).

## Timing
- Values after reset:
  - Outputs: `busy_o`=0, `done_o`=0, `moved_count_o`=0, `ram_write_en_o`=0, write/read addresses 0, `ram_write_data_o`=0.
  - State: IDLE, `prefer_left`=1.
- `start_i` high in IDLE at cycle n → `busy_o`=1 and first read address driven at n+1.
- Read latency is exactly 1 cycle; each CHECK state consumes the data for the read issued in the previous cycle.
- Per-cell cost:
  - Empty cell: 2 cycles.
  - Straight fall: 5 cycles.
  - Blocked grain: 3–5 cycles, depending on diagonals available.
  - Diagonal fall: 6–7 cycles.
- Empty-grid pass: 2*(ACTIVE_ROWS−1)*ACTIVE_COLUMNS cycles, plus 1 for FINISH. At default sizes that is 613,121 cycles; the caller paces `start_i` accordingly.
- FINISH cycle: `done_o`=1 and `busy_o`=0 in the same cycle. `moved_count_o` is valid from that cycle and holds until the next FINISH.
- Reset mid-pass: IDLE on the next edge, write strobe deasserted immediately, grid left partially updated (no rollback), `prefer_left` reset to 1.

## Test plan
Unless noted, benches use ACTIVE_COLUMNS=4, ACTIVE_ROWS=4 with a behavioural 1-cycle-latency RAM model.
- Empty grid, one `start_i` → no writes; `done_o` exactly 25 cycles after start (24 + FINISH); `moved_count_o`=0.
- Single grain at (1,0), three passes → grain at (1,1), then (1,2), then (1,3), each with `moved_count_o`=1; a fourth pass gives `moved_count_o`=0.
- Two grains stacked at (1,2),(1,3), first pass (`prefer_left`=1) → (1,2) moves to (0,3) via WRITE_DST addr 12 then WRITE_SRC addr 9. After a reset, a grain at (1,2) over a blocked (1,3) and (0,3) with `prefer_left`=0 → moves to (2,3), addr 14.
- Edge handling: grain at (0,2) over (0,3)=1, (1,3)=1 → no BL read ever issued and no move. Grain at (3,2) over (3,3)=1, (2,3)=1 → no BR read ever issued and no move.
- `start_i` held high through a whole pass → exactly one pass, then a new pass starts the cycle after FINISH. Reset asserted mid-WRITE_DST → `ram_write_en_o`=0 and `busy_o`=0 on the next cycle.
